// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - synchronized, optionally debounced load/clear buttons driving an A/B/opcode FSM
// Optional debouncer on btn_load enabled by OPERAND_LOADER_DEBOUNCE_EN.
module operand_loader #(
   parameter int DEB_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw,
   input  logic       btn_load,
   input  logic       btn_clear,
   output logic [3:0] A_num,
   output logic [3:0] B_num,
   output logic [1:0] ALUControl,
   output logic       op_valid,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      S_A   = 2'b00,
      S_B   = 2'b01,
      S_OP  = 2'b10,
      S_RDY = 2'b11
   } state_t;

   state_t state;
   logic   load_s1, load_s2, clr_s1, clr_s2;
   logic   lvl, lvl_d, load_evt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_s1 <= 1'b0;
         load_s2 <= 1'b0;
         clr_s1  <= 1'b0;
         clr_s2  <= 1'b0;
      end else begin
         load_s1 <= btn_load;
         load_s2 <= load_s1;
         clr_s1  <= btn_clear;
         clr_s2  <= clr_s1;
      end
   end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEB_CYCLES) + 1;

   logic [CNT_W-1:0] deb_cnt;
   logic             stable;

   // Level flips only after DEB_CYCLES consecutive samples disagree with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_cnt <= '0;
         stable  <= 1'b0;
      end else if (load_s2 != stable) begin
         if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
            stable  <= ~stable;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end else begin
         deb_cnt <= '0;
      end
   end

   assign lvl = stable;
`else
   logic unused_deb;
   assign unused_deb = ^DEB_CYCLES;
   assign lvl        = load_s2;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lvl_d <= 1'b0;
      else      lvl_d <= lvl;
   end

   assign load_evt = lvl & ~lvl_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_A;
         A_num      <= '0;
         B_num      <= '0;
         ALUControl <= '0;
         op_valid   <= 1'b0;
      end else begin
         op_valid <= 1'b0;
         if (clr_s2) begin
            state      <= S_A;
            A_num      <= '0;
            B_num      <= '0;
            ALUControl <= '0;
         end else if (load_evt) begin
            case (state)
               S_A: begin
                  A_num <= sw;
                  state <= S_B;
               end
               S_B: begin
                  B_num <= sw;
                  state <= S_OP;
               end
               S_OP: begin
                  ALUControl <= sw[1:0];
                  op_valid   <= 1'b1;
                  state      <= S_RDY;
               end
               default: begin
                  A_num <= sw;
                  state <= S_B;
               end
            endcase
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable cycles required before a debounced button changes state.
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 sw  input  4  raw switch value, captured as operand or opcode.
REQ-005 btn_load  input  1  raw active-high load button, asynchronous to clk.
REQ-006 btn_clear  input  1  raw active-high clear button, asynchronous to clk.
REQ-007 A_num  output  4  registered operand A, feeds the motor-controller ALU.
REQ-008 B_num  output  4  registered operand B, feeds the motor-controller ALU.
REQ-009 ALUControl  output  2  registered opcode: 00 add, 01 sub, 10 AND, 11 OR.
REQ-010 op_valid  output  1  one-cycle pulse when a complete A/B/op set is loaded.
REQ-011 state_dbg  output  2  current FSM state encoding, for LEDs.

Function
REQ-012 btn_load and btn_clear SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 Synchronized btn_load SHALL feed a debouncer: counter increments while input differs from stable level, clears when equal; stable level toggles and counter clears when count reaches DEB_CYCLES-1.
REQ-014 A load event SHALL be a one-cycle pulse on the rising edge of the stable level (registered edge detect); falling edges produce no event.
REQ-015 Fixed latency: load event captured at rising edge DEB_CYCLES+3 after btn_load is first sampled high and held; glitches shorter than DEB_CYCLES cycles SHALL produce no event.
REQ-016 FSM states: S_A=00, S_B=01, S_OP=10, S_RDY=11; state_dbg SHALL equal the state register.
REQ-017 S_A + load event: A_num<=sw, go S_B.
REQ-018 S_B + load event: B_num<=sw, go S_OP.
REQ-019 S_OP + load event: ALUControl<=sw[1:0], go S_RDY, op_valid=1 the following cycle only.
REQ-020 S_RDY + load event: A_num<=sw, go S_B (new sequence); B_num and ALUControl hold until overwritten.
REQ-021 Outputs SHALL hold between load events; no output changes without a load event or clear.
REQ-022 Synchronized btn_clear high (level, not debounced) SHALL set A_num, B_num, ALUControl to 0, state to S_A, op_valid to 0 every cycle it is high.
REQ-023 Clear and load event in the same cycle: clear wins, load event discarded.
REQ-024 Debounce counter SHALL saturate-free wrap cannot occur; width = clog2(DEB_CYCLES)+1.

Reset
REQ-025 rst low SHALL asynchronously force A_num=0, B_num=0, ALUControl=00, op_valid=0, state S_A, synchronizer flops, stable level and counter to 0.
REQ-026 Reset asserted mid-sequence SHALL discard partially loaded operands; release resumes in S_A with no spurious load event even if btn_load is held high (stable level rises only after debounce, yielding one event).

Configuration
REQ-027 Macro OPERAND_LOADER_DEBOUNCE_EN defined: debouncer per REQ-013/015 present.
REQ-028 Macro undefined: debouncer removed, edge detect on synchronized btn_load directly; capture latency 3 rising edges; DEB_CYCLES ignored.

Verification
REQ-029 rst low 5 time units then high, all inputs 0 -> A_num=0, B_num=0, ALUControl=00, state_dbg=00, op_valid=0.
REQ-030 sw=0010 press, sw=0011 press, sw=0000 press (each held 40 cycles) -> A_num=2, B_num=3, ALUControl=00, one op_valid pulse, state_dbg=11.
REQ-031 btn_load glitch high 5 cycles, DEB_CYCLES=16 -> no state change; with macro undefined -> A_num captured at 3rd edge.
REQ-032 From S_RDY, sw=0100 press -> A_num=4, state_dbg=01, B_num and ALUControl unchanged.
REQ-033 btn_clear and btn_load both reach sync stage on same cycle in S_B -> all outputs 0, state_dbg=00.
REQ-034 rst pulsed low while in S_OP with btn_load held -> outputs 0, exactly one load event DEB_CYCLES+3 edges after release, A_num=sw.
